pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register for the EX->MEM boundary. It replaces the free-running stage register.
- Carries control bits, ALU result, store data and destination register address.
- Adds valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, synchronous flush and bubble masking.
- Sits between the ALU/forwarding mux output and the data-memory stage; the same block is reused for other stage boundaries by re-parametrising.

Parameters:
- XLEN, 32, width of alu_result and store_data payloads.
- RD_W, 5, width of destination register address.
- CTRL_W, 4, control bit count; bit order [0]=RegWrite, [1]=MemWrite, [2]=MemRead, [3]=MemtoReg.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; discards all held and incoming entries.
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  stage can accept an entry this cycle.
- ctrl_i  in  CTRL_W  control bits.
- alu_result_i  in  XLEN  ALU result.
- store_data_i  in  XLEN  forwarded rs2 value (store data).
- rd_addr_i  in  RD_W  destination register.
- out_valid_o  out  1  downstream entry valid.
- out_ready_i  in  1  downstream accepts entry.
- ctrl_o  out  CTRL_W  control bits; forced 0 when out_valid_o=0.
- alu_result_o  out  XLEN  ALU result.
- store_data_o  out  XLEN  store data.
- rd_addr_o  out  RD_W  destination register.

Behaviour:
- Storage: main slot (drives outputs) and skid slot. State encodes occupancy: EMPTY (none), FULL (main only), SKID (main+skid).
- Transfers: in-transfer = in_valid_i & in_ready_o. Out-transfer = out_valid_o & out_ready_i.
- in_ready_o = (state != SKID). It is driven from the registered state, with no combinational path from out_ready_i.
- out_valid_o = (state != EMPTY).
- Latency: 1 cycle from in-transfer to out_valid_o. Throughput: 1 entry/cycle when out_ready_i=1.
- EMPTY: in_valid_i -> main<=in, go FULL.
- FULL:
  - out_ready_i & in_valid_i -> main<=in, stay FULL.
  - out_ready_i & !in_valid_i -> EMPTY.
  - !out_ready_i & in_valid_i -> skid<=in, go SKID.
  - Neither -> hold.
- SKID: in_ready_o=0, inputs ignored. out_ready_i -> main<=skid, go FULL. Otherwise hold both slots.
- Ordering is strictly FIFO; no entry is ever duplicated or dropped except by flush.
- Flush (highest priority over any transfer in the same cycle):
  - Next state EMPTY.
  - Any in-transfer in that cycle is discarded.
  - The downstream out-transfer in that cycle still completes (downstream already sampled it).
- Bubble masking: ctrl_o = 0 whenever out_valid_o=0, so MemWrite/RegWrite never fire on a bubble. Other outputs hold the last main-slot value (don't-care).
- Reset (rst_i=0, asynchronous):
  - State EMPTY; all payload registers 0.
  - Outputs: out_valid_o=0, ctrl_o=0, alu_result_o=0, store_data_o=0, rd_addr_o=0, in_ready_o=1.
  - Reset mid-stream discards both slots.
  - Deassertion is synchronised externally; the first rising edge after deassertion behaves as EMPTY.
- Upstream must hold payload stable while in_valid_i=1 and in_ready_o=0. The block does not check this.
- Payload registers load only on slot write; no other widening, truncation or arithmetic.

Optional Feature:
- Macro PIPE_STAGE_ZERO_EN.
- Defined: adds ports zero_i (in, 1) and zero_o (out, 1), carried as part of the payload through both slots with identical timing. zero_o is 0 at reset and masked to 0 when out_valid_o=0.
- Undefined: the ports are absent, and neither slot stores a zero bit.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL_W default.
  - Control bit index constants CTRL_REGWRITE=0, CTRL_MEMWRITE=1, CTRL_MEMREAD=2, CTRL_MEMTOREG=3.
  - Occupancy state typedef {EMPTY, FULL, SKID}.
- Sub-module pipe_payload_slot: load-enabled, async-reset payload register of width CTRL_W+2*XLEN+RD_W(+1). Instantiated twice, as main and skid.

Test Plan:
- Reset: assert rst_i=0 mid-FULL -> outputs go to 0 immediately, without waiting for a clock edge; out_valid_o=0 and in_ready_o=1.
- Streaming: out_ready_i=1, send alu_result 0x10,0x20,0x30 on consecutive cycles -> same values on alu_result_o one cycle later, back-to-back, out_valid_o continuous.
- Back-pressure: send A=0xAAAA0000, B=0xBBBB0000 with out_ready_i=0 -> state SKID, in_ready_o=0. Then hold out_ready_i=1 for 2 cycles -> A then B emitted, in_ready_o back to 1.
- Flush: in SKID, assert flush_i=1 with in_valid_i=1 (C=0xCC) -> next cycle out_valid_o=0, ctrl_o=0; C never appears on the outputs.
- Bubble masking: ctrl_i=4'b0010 (MemWrite) accepted then drained, no new input -> ctrl_o=0 once out_valid_o=0, while alu_result_o keeps its stale value.
- PIPE_STAGE_ZERO_EN defined: zero_i=1 with entry D -> zero_o=1 with D, 0 on the following bubble.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-bit indices, default widths and occupancy states for pipe_stage_reg
package pipe_pkg;
  localparam int CTRL_W_DEFAULT = 4;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMREAD = 2;
  localparam int CTRL_MEMTOREG = 3;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} occ_e;
endpackage

// File: rtl/pipe_payload_slot.sv
// pipe_payload_slot: load-enabled payload register, async active-low reset to zero
// Ports: clk_i clock, rst_i async active-low reset, en_i load enable, d_i payload in, q_o stored payload
module pipe_payload_slot
  import pipe_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q, data_d;
  always_comb data_d = en_i ? d_i : data_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) data_q <= '0;
    else data_q <= data_d;
  assign q_o = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic EX->MEM pipeline register with 2-entry skid buffer, sync flush and bubble masking
// Ports: clk_i clock; rst_i async active-low reset; flush_i sync flush;
//   in_valid_i/in_ready_o + ctrl_i, alu_result_i, store_data_i, rd_addr_i upstream;
//   out_valid_o/out_ready_i + ctrl_o, alu_result_o, store_data_o, rd_addr_o downstream.
// Optional: define PIPE_STAGE_ZERO_EN to add zero_i/zero_o, carried through both slots with the payload.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = CTRL_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [RD_W-1:0]   rd_addr_i,
`ifdef PIPE_STAGE_ZERO_EN
  input  logic              zero_i,
  output logic              zero_o,
`endif
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [XLEN-1:0]   alu_result_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [RD_W-1:0]   rd_addr_o
);
`ifdef PIPE_STAGE_ZERO_EN
  localparam int ZW = 1;
`else
  localparam int ZW = 0;
`endif
  localparam int PW = CTRL_W + 2*XLEN + RD_W + ZW;
  occ_e state_q, state_d;
  logic main_en, skid_en;
  logic [PW-1:0] in_pay, main_d, main_q, skid_q;
  logic [CTRL_W-1:0] ctrl_m;
`ifdef PIPE_STAGE_ZERO_EN
  logic zero_m;
  assign in_pay = {zero_i, ctrl_i, alu_result_i, store_data_i, rd_addr_i};
  assign {zero_m, ctrl_m, alu_result_o, store_data_o, rd_addr_o} = main_q;
  assign zero_o = out_valid_o & zero_m;
`else
  assign in_pay = {ctrl_i, alu_result_i, store_data_i, rd_addr_i};
  assign {ctrl_m, alu_result_o, store_data_o, rd_addr_o} = main_q;
`endif
  // Ready depends only on registered occupancy, so no out_ready_i -> in_ready_o path exists.
  assign in_ready_o  = state_q != SKID;
  assign out_valid_o = state_q != EMPTY;
  assign ctrl_o      = out_valid_o ? ctrl_m : '0;
  // Main refills from skid when draining SKID, otherwise straight from the input.
  assign main_d = (state_q == SKID) ? skid_q : in_pay;
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    case (state_q)
      EMPTY: begin
        main_en = in_valid_i;
        state_d = in_valid_i ? FULL : EMPTY;
      end
      FULL: begin
        main_en = in_valid_i & out_ready_i;
        skid_en = in_valid_i & ~out_ready_i;
        state_d = in_valid_i ? (out_ready_i ? FULL : SKID) : (out_ready_i ? EMPTY : FULL);
      end
      SKID: begin
        main_en = out_ready_i;
        state_d = out_ready_i ? FULL : SKID;
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins: nothing is captured, but the outgoing transfer already happened downstream.
    if (flush_i) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state_q <= EMPTY;
    else state_q <= state_d;
  pipe_payload_slot #(.W(PW)) u_main (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(main_en), .d_i(main_d), .q_o(main_q)
  );
  pipe_payload_slot #(.W(PW)) u_skid (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(skid_en), .d_i(in_pay), .q_o(skid_q)
  );
endmodule
